// File: rtl/ram_block_mover_if.sv
// Command/status and RAM-port bundle for ram_block_mover.
// master: the block mover itself (drives the RAM port and status).
// slave : the requester plus the RAM (drives commands and mem_out).
// Handshake: start is a level request sampled on the rising clock edge and
// is taken only while busy=0 and done=0 (IDLE); it is never queued.
// done is a single-cycle completion pulse. busy stays high from the first
// RAM cycle to the last.
interface ram_block_mover_if #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 64
);
   logic              start;
   logic              op;
   logic [ADDR_W-1:0] src;
   logic [ADDR_W-1:0] dst;
   logic [8:0]        len;
   logic [DATA_W-1:0] fill_data;
   logic              busy;
   logic              done;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_in;
   logic              mem_write;
   logic [DATA_W-1:0] mem_out;

   modport master (
      input  start, op, src, dst, len, fill_data, mem_out,
      output busy, done, mem_address, mem_in, mem_write
   );

   modport slave (
      output start, op, src, dst, len, fill_data, mem_out,
      input  busy, done, mem_address, mem_in, mem_write
   );
endinterface

// File: rtl/ram_block_mover.sv
// Single-port RAM master that copies a block of words or fills a block with
// a constant. The RAM samples on the falling edge; this block runs on the
// rising edge. All RAM-port outputs are registered, so mem_in never follows
// mem_out combinationally.
// Debug state encoding on o_dbg_state: 0 IDLE, 1 RD, 2 WR, 3 FILL, 4 DONE.
module ram_block_mover #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 64
) (
   input  logic              clock,
   input  logic              reset,
   ram_block_mover_if.master bus,
   output logic [2:0]        o_dbg_state
);
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WR   = 3'd2,
      S_FILL = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t            r_state;
   logic [8:0]        r_i;
   logic [8:0]        r_len;
   logic [ADDR_W-1:0] r_src;
   logic [ADDR_W-1:0] r_dst;
   logic [DATA_W-1:0] r_data;   // copied word in copy mode, pattern in fill mode
   logic [ADDR_W-1:0] r_addr;
   logic              r_write;
   logic              r_busy;
   logic              r_done;

   logic [8:0]        w_i_next;
   logic              w_last;
   logic [ADDR_W-1:0] w_src_next;
   logic [ADDR_W-1:0] w_dst_cur;
   logic [ADDR_W-1:0] w_dst_next;

   // Index arithmetic; base+i wraps modulo the RAM depth by truncation.
   assign w_i_next   = r_i + 9'd1;
   assign w_last     = (w_i_next >= r_len);
   assign w_src_next = r_src + w_i_next[ADDR_W-1:0];
   assign w_dst_cur  = r_dst + r_i[ADDR_W-1:0];
   assign w_dst_next = r_dst + w_i_next[ADDR_W-1:0];

   // Transfer sequencer with registered RAM-port and status outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_i     <= '0;
         r_len   <= '0;
         r_src   <= '0;
         r_dst   <= '0;
         r_data  <= '0;
         r_addr  <= '0;
         r_write <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_write <= 1'b0;
               r_addr  <= '0;
               r_data  <= '0;
               if (bus.start) begin
                  r_src <= bus.src;
                  r_dst <= bus.dst;
                  r_len <= bus.len;
                  r_i   <= '0;
                  if (bus.len == 9'd0) begin
                     r_state <= S_DONE;
                     r_done  <= 1'b1;
                  end else if (!bus.op) begin
                     r_state <= S_RD;
                     r_busy  <= 1'b1;
                     r_addr  <= bus.src;
                  end else begin
                     r_state <= S_FILL;
                     r_busy  <= 1'b1;
                     r_addr  <= bus.dst;
                     r_data  <= bus.fill_data;
                     r_write <= 1'b1;
                  end
               end
            end
            S_RD: begin
               // mem_out was refreshed at the falling edge inside this cycle.
               r_data  <= bus.mem_out;
               r_addr  <= w_dst_cur;
               r_write <= 1'b1;
               r_state <= S_WR;
            end
            S_WR: begin
               r_i <= w_i_next;
               if (w_last) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_write <= 1'b0;
                  r_addr  <= '0;
                  r_data  <= '0;
               end else begin
                  r_state <= S_RD;
                  r_addr  <= w_src_next;
                  r_write <= 1'b0;
               end
            end
            S_FILL: begin
               r_i <= w_i_next;
               if (w_last) begin
                  r_state <= S_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_write <= 1'b0;
                  r_addr  <= '0;
                  r_data  <= '0;
               end else begin
                  r_addr <= w_dst_next;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_done  <= 1'b0;
               r_busy  <= 1'b0;
               r_write <= 1'b0;
               r_addr  <= '0;
               r_data  <= '0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
               r_write <= 1'b0;
               r_addr  <= '0;
               r_data  <= '0;
            end
         endcase
      end
   end

   assign bus.busy        = r_busy;
   assign bus.done        = r_done;
   assign bus.mem_address = r_addr;
   assign bus.mem_in      = r_data;
   assign bus.mem_write   = r_write;
   assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_ram_block_mover.sv
// Bench for ram_block_mover: a falling-edge 256x64 RAM model, a reference
// memory updated with plain array copies/fills, an expected write queue,
// a table of directed transfers, hand-written corner sequences and
// randomized transfers.
module tb_ram_block_mover;
   logic       clk;
   logic       rst;
   logic [2:0] dbg_state;

   ram_block_mover_if #(.ADDR_W(8), .DATA_W(64)) bus ();

   ram_block_mover #(.ADDR_W(8), .DATA_W(64)) dut (
      .clock       (clk),
      .reset       (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model plus a bench-side preload port
   logic [63:0] ram [256];
   logic [63:0] ref_mem [256];
   logic        tb_we;
   logic [7:0]  tb_addr;
   logic [63:0] tb_data;

   always @(negedge clk) begin
      if (tb_we) ram[tb_addr] <= tb_data;
      else if (bus.mem_write) ram[bus.mem_address] <= bus.mem_in;
      bus.mem_out <= ram[bus.mem_address];
   end

   // Scoreboard
   logic [71:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic        op;
      int          src;
      int          dst;
      int          len;
      logic [63:0] fill;
      int          exp_busy;
      int          exp_done_cyc;
      int          exp_writes;
   } vec_t;

   vec_t vecs[8];

   task automatic check_int(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_v(input string name, input logic [71:0] act, input logic [71:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_mem(input string name);
      int bad = 0;
      int first = -1;
      for (int a = 0; a < 256; a++) begin
         if (ram[a] !== ref_mem[a]) begin
            bad++;
            if (first < 0) first = a;
         end
      end
      n_tests++;
      if (bad != 0) begin
         n_fail++;
         $display("FAIL %s: %0d words differ, first at %0d got %0h expected %0h",
                  name, bad, first, ram[first], ref_mem[first]);
      end
   endtask

   task automatic ram_put(input logic [7:0] a, input logic [63:0] d);
      @(posedge clk);
      #1;
      tb_we   = 1'b1;
      tb_addr = a;
      tb_data = d;
      @(negedge clk);
      #1;
      tb_we = 1'b0;
      ref_mem[a] = d;
   endtask

   // Reference: ascending word-by-word copy or fill, first n words only.
   task automatic apply_ref(input logic op, input int src, input int dst,
                            input logic [63:0] fill, input int n);
      logic [7:0]  a;
      logic [63:0] d;
      for (int j = 0; j < n; j++) begin
         a = 8'((dst + j) % 256);
         d = op ? fill : ref_mem[(src + j) % 256];
         exp_q.push_back({a, d});
         ref_mem[a] = d;
      end
   endtask

   task automatic run_xfer(input logic op, input int src, input int dst, input int len,
                           input logic [63:0] fill, input bit spam,
                           output int busy_cyc, output int done_cyc,
                           output int done_cnt, output int wr_cnt);
      logic [71:0] exp_w;
      busy_cyc = 0;
      done_cyc = -1;
      done_cnt = 0;
      wr_cnt   = 0;
      exp_q.delete();
      apply_ref(op, src, dst, fill, len);
      @(posedge clk);
      #1;
      bus.start     = 1'b1;
      bus.op        = op;
      bus.src       = 8'(src);
      bus.dst       = 8'(dst);
      bus.len       = 9'(len);
      bus.fill_data = fill;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      for (int c = 0; c < 700; c++) begin
         @(negedge clk);
         if (bus.busy) busy_cyc++;
         if (bus.mem_write) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
               check_v("wr_unexpected", {bus.mem_address, bus.mem_in}, 72'hx);
            end else begin
               exp_w = exp_q.pop_front();
               check_v("wr_stream", {bus.mem_address, bus.mem_in}, exp_w);
            end
         end
         if (bus.done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (spam) begin
            if (done_cnt == 0) begin
               bus.start     = 1'b1;
               bus.op        = 1'($urandom_range(0, 1));
               bus.src       = 8'($urandom);
               bus.dst       = 8'($urandom);
               bus.len       = 9'($urandom_range(1, 256));
               bus.fill_data = {$urandom, $urandom};
            end else begin
               bus.start = 1'b0;
            end
         end
         if (done_cyc >= 0 && c >= done_cyc + 3) break;
      end
      bus.start = 1'b0;
      if (done_cyc < 0) $display("FAIL timeout: no done within 700 cycles");
      check_int("wr_missing", exp_q.size(), 0);
      exp_q.delete();
   endtask

   int busy_c, done_c, done_n, wr_n, exp_n;
   logic        r_op;
   int          r_src, r_dst, r_len;
   logic [63:0] r_fill;

   initial begin
      // Directed table: {op, src, dst, len, fill, busy cycles, done cycle, writes}
      vecs[0] = '{1'b0, 10, 100, 4, 64'h0, 8, 8, 4};
      vecs[1] = '{1'b1, 0, 250, 10, 64'hDEAD_BEEF_0000_0001, 10, 10, 10};
      vecs[2] = '{1'b0, 5, 6, 0, 64'h0, 0, 0, 0};
      vecs[3] = '{1'b1, 0, 7, 0, 64'h1234, 0, 0, 0};
      vecs[4] = '{1'b0, 20, 22, 6, 64'h0, 12, 12, 6};
      vecs[5] = '{1'b0, 254, 3, 5, 64'h0, 10, 10, 5};
      vecs[6] = '{1'b1, 0, 0, 256, 64'hA5A5_5A5A_0F0F_F0F0, 256, 256, 256};
      vecs[7] = '{1'b0, 255, 0, 1, 64'h0, 2, 2, 1};

      rst = 1'b1;
      tb_we = 1'b0;
      tb_addr = '0;
      tb_data = '0;
      bus.start = 1'b0;
      bus.op = 1'b0;
      bus.src = '0;
      bus.dst = '0;
      bus.len = '0;
      bus.fill_data = '0;

      // Reset values
      repeat (2) @(posedge clk);
      #1;
      check_int("rst_busy", int'(bus.busy), 0);
      check_int("rst_done", int'(bus.done), 0);
      check_int("rst_write", int'(bus.mem_write), 0);
      check_int("rst_addr", int'(bus.mem_address), 0);
      check_v("rst_in", 72'(bus.mem_in), 72'h0);
      check_int("rst_state_idle", int'(dbg_state), 0);
      rst = 1'b0;

      // Preload RAM with random data, then the A..D block at 10..13
      for (int a = 0; a < 256; a++) ram_put(8'(a), {$urandom, $urandom});
      ram_put(8'd10, 64'hAAAA_0000_0000_000A);
      ram_put(8'd11, 64'hBBBB_0000_0000_000B);
      ram_put(8'd12, 64'hCCCC_0000_0000_000C);
      ram_put(8'd13, 64'hDDDD_0000_0000_000D);

      // Directed table
      for (int v = 0; v < 8; v++) begin
         run_xfer(vecs[v].op, vecs[v].src, vecs[v].dst, vecs[v].len, vecs[v].fill, 1'b0,
                  busy_c, done_c, done_n, wr_n);
         check_int($sformatf("v%0d_busy", v), busy_c, vecs[v].exp_busy);
         check_int($sformatf("v%0d_done_cyc", v), done_c, vecs[v].exp_done_cyc);
         check_int($sformatf("v%0d_done_cnt", v), done_n, 1);
         check_int($sformatf("v%0d_writes", v), wr_n, vecs[v].exp_writes);
         check_mem($sformatf("v%0d_mem", v));
      end
      check_int("idle_after_table", int'(dbg_state), 0);

      // New start every cycle during a 3-word copy: only the first runs
      run_xfer(1'b0, 60, 200, 3, 64'h0, 1'b1, busy_c, done_c, done_n, wr_n);
      check_int("spam_busy", busy_c, 6);
      check_int("spam_done_cnt", done_n, 1);
      check_int("spam_writes", wr_n, 3);
      check_mem("spam_mem");

      // Reset during the third WR cycle of a 5-word copy, before its falling edge
      exp_q.delete();
      apply_ref(1'b0, 40, 70, 64'h0, 2);
      exp_q.delete();
      @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.op    = 1'b0;
      bus.src   = 8'd40;
      bus.dst   = 8'd70;
      bus.len   = 9'd5;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check_int("abort_busy", int'(bus.busy), 0);
      check_int("abort_done", int'(bus.done), 0);
      check_int("abort_write", int'(bus.mem_write), 0);
      check_int("abort_addr", int'(bus.mem_address), 0);
      check_v("abort_in", 72'(bus.mem_in), 72'h0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      done_n = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (bus.done) done_n++;
      end
      check_int("abort_no_done", done_n, 0);
      check_mem("abort_mem");
      run_xfer(1'b1, 0, 130, 3, 64'h0BAD_F00D_0000_0042, 1'b0, busy_c, done_c, done_n, wr_n);
      check_int("post_abort_done_cyc", done_c, 3);
      check_mem("post_abort_mem");

      // Randomized transfers
      for (int t = 0; t < 20; t++) begin
         r_op   = 1'($urandom_range(0, 1));
         r_src  = $urandom_range(0, 255);
         r_dst  = $urandom_range(0, 255);
         r_len  = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 40);
         r_fill = {$urandom, $urandom};
         run_xfer(r_op, r_src, r_dst, r_len, r_fill, 1'b0, busy_c, done_c, done_n, wr_n);
         exp_n = r_op ? r_len : 2 * r_len;
         check_int($sformatf("rnd%0d_busy", t), busy_c, exp_n);
         check_int($sformatf("rnd%0d_done_cyc", t), done_c, exp_n);
         check_int($sformatf("rnd%0d_done_cnt", t), done_n, 1);
         check_int($sformatf("rnd%0d_writes", t), wr_n, r_len);
         check_mem($sformatf("rnd%0d_mem", t));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/ram_block_mover.md
# ram_block_mover

Single-port master for the 256x64 RAM: drives its `address`, `in` and `write` inputs and consumes its `out` data. On a `start` request it either copies `len` consecutive words from `src` to `dst`, or fills `len` words at `dst` with a constant. It frees higher-level logic from sequencing RAM cycles by hand, and is the only agent on the RAM port while busy.

## Interface
- `ADDR_W`, default 8: RAM address width; 256 words.
- `DATA_W`, default 64: word width.
- `clock` input, 1 bit: single clock; RAM samples on falling edge, this block on rising edge.
- `reset` input, 1 bit: asynchronous, active-high.
- `start` input, 1 bit: request, sampled on rising edge; accepted only in IDLE.
- `op` input, 1 bit: 0 = copy, 1 = fill; latched on accept.
- `src` input, ADDR_W: copy source base; latched on accept.
- `dst` input, ADDR_W: destination base; latched on accept.
- `len` input, 9 bits: word count 0..256; latched on accept.
- `fill_data` input, DATA_W: fill pattern; latched on accept.
- `busy` output, 1 bit: high while a transfer is in progress.
- `done` output, 1 bit: one-cycle pulse when a transfer completes.
- `mem_address` output, ADDR_W: to RAM `address`.
- `mem_in` output, DATA_W: to RAM `in`.
- `mem_write` output, 1 bit: to RAM `write`.
- `mem_out` input, DATA_W: from RAM `out`.

## Operation
- States: IDLE, RD, WR, FILL, DONE.
- IDLE + `start`:
  - `len`=0 → DONE.
  - op=0 → RD.
  - op=1 → FILL.
  - Index `i` cleared to 0.
- RD (copy): `mem_address`=src+i, `mem_write`=0. The RAM updates `mem_out` at the falling edge; the block captures `mem_out` into an internal data register at the next rising edge. → WR.
- WR (copy): `mem_address`=dst+i, `mem_in`=data register, `mem_write`=1. Then `i`+1; → RD if `i`+1 < len, else → DONE.
- FILL: `mem_address`=dst+i, `mem_in`=latched fill_data, `mem_write`=1. Then `i`+1; stay if `i`+1 < len, else → DONE.
- DONE: `done`=1, `busy`=0, `mem_write`=0. Unconditionally → IDLE.
- Address arithmetic: base+i is 8-bit modulo 256; wraps 255→0 silently.
- Copy is strictly ascending. Overlapping ranges with dst > src propagate already-written words. This is defined behaviour, not an error.
- `start` outside IDLE is ignored; no queuing.
- `busy`=1 in RD, WR and FILL; 0 otherwise.
- In IDLE and DONE: `mem_address`=0, `mem_in`=0, `mem_write`=0.
- `mem_in` is never driven combinationally from `mem_out`. This avoids a falling-edge race when the RAM overwrites `out` during WR.

## Timing
- Reset (asynchronous): state=IDLE; `busy`=0, `done`=0, `mem_write`=0, `mem_address`=0, `mem_in`=0; `i` and data register cleared.
- Reset asserted before a falling edge suppresses that RAM write.
- Start accepted at edge k: first RD or FILL cycle is k..k+1.
- Copy of N words:
  - 2N busy cycles.
  - Write of word j occurs on the falling edge inside cycle 2j+1 after accept.
  - `done` high during cycle 2N.
  - Back in IDLE at edge k+2N+1.
- Fill of N words: N busy cycles; `done` high during cycle N.
- `len`=0: `done` in the cycle after accept; no RAM write; `busy` never rises.
- Earliest next accepted `start` is the edge ending the DONE cycle +1, i.e. in IDLE.
- Reset mid-transfer: abort immediately. Words already written remain; no `done` pulse.

## Test plan
- Preload RAM[10..13]=A,B,C,D; copy src=10, dst=100, len=4 → RAM[100..103]=A..D; RAM[10..13] unchanged; `busy` high 8 cycles; single `done` pulse; RAM[104] untouched.
- Fill dst=250, len=10, fill_data=64'hDEAD_BEEF_0000_0001 → RAM[250..255] and RAM[0..3] hold the pattern; 10 `mem_write` cycles; RAM[4] unchanged.
- len=0, either op → `done` one cycle after accept; zero `mem_write` pulses; `busy` stays 0.
- Assert `start` with new operands every cycle during a copy len=3 → only the first request executes; exactly one `done`.
- Fill len=256 from dst=0 → all 256 words written; `done` at cycle 256.
- Assert `reset` during the 3rd WR cycle, before its falling edge, of copy len=5 → only 2 words written; all outputs 0 at once; no `done`; next `start` accepted normally.
